// File: rtl/signed_alu_sched_pkg.sv
// Shared definitions for the signed ALU scheduler: op encoding, FSM states
// and the default operand width.
package signed_alu_sched_pkg;

    localparam int W_DEFAULT = 6;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/signed_alu_sched_core.sv
// Combinational signed add / multiply with a W-bit signed range check on the
// 2*W-bit result.
module signed_alu_core
    import signed_alu_sched_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic           op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] result,
    output logic           ovf
);

    logic [W:0]     sum;
    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] b_ext;
    logic [2*W-1:0] prod;

    always_comb begin
        sum   = {a[W-1], a} + {b[W-1], b};
        a_ext = {{W{a[W-1]}}, a};
        b_ext = {{W{b[W-1]}}, b};
        // Low 2*W bits of the product of sign-extended operands are the exact signed product.
        prod  = a_ext * b_ext;
        if (op == OP_MUL) begin
            result = prod;
        end else begin
            result = {{(W-1){sum[W]}}, sum};
        end
        // Fits in W signed bits only when the top W+1 bits are all equal.
        ovf = ~((&result[2*W-1:W-1]) | ~(|result[2*W-1:W-1]));
    end

endmodule

// File: rtl/signed_alu_sched.sv
// Two-requester round-robin scheduler around a shared signed add/multiply
// unit; one operation in flight at a time, no queueing.
module signed_alu_sched
    import signed_alu_sched_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req,
    input  logic [1:0]     op,
    input  logic [2*W-1:0] a,
    input  logic [2*W-1:0] b,
    output logic [1:0]     gnt,
    output logic [1:0]     done,
    output logic [2*W-1:0] result,
    output logic           ovf,
    output logic           busy
);

    state_t         state_q, state_d;
    logic           last_q, last_d;
    logic           sel_q, sel_d;
    logic           cnt_q, cnt_d;
    logic           op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [1:0]     gnt_q, gnt_d;
    logic [1:0]     done_q, done_d;
    logic [2*W-1:0] result_q, result_d;
    logic           ovf_q, ovf_d;

    logic           win;
    logic [2*W-1:0] alu_result;
    logic           alu_ovf;

    signed_alu_core #(.W(W)) u_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    // last_q holds the requester served most recently; resetting it to 1 favours requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            sel_q    <= 1'b0;
            cnt_q    <= 1'b0;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|req) state_d = ST_EXEC;
            ST_EXEC: if (op_q == OP_ADD || cnt_q) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        win      = (req == 2'b11) ? ~last_q : req[1];
        last_d   = last_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        gnt_d    = 2'b00;
        done_d   = 2'b00;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    sel_d = win;
                    op_d  = win ? op[1] : op[0];
                    a_d   = win ? a[2*W-1:W] : a[W-1:0];
                    b_d   = win ? b[2*W-1:W] : b[W-1:0];
                    gnt_d = win ? 2'b10 : 2'b01;
                    cnt_d = 1'b0;
                end
            end
            ST_EXEC: cnt_d = 1'b1;
            ST_DONE: begin
                done_d   = sel_q ? 2'b10 : 2'b01;
                result_d = alu_result;
                ovf_d    = alu_ovf;
                last_d   = sel_q;
                cnt_d    = 1'b0;
            end
            default: ;
        endcase
        busy   = (state_q != ST_IDLE);
        gnt    = gnt_q;
        done   = done_q;
        result = result_q;
        ovf    = ovf_q;
    end

endmodule

// File: tb/tb_signed_alu_sched.sv
// Randomised and directed stimulus for signed_alu_sched, checked by a
// scoreboard fed from an integer-arithmetic reference model.
module tb_signed_alu_sched;

  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     req = 2'b00;
  logic [1:0]     op = 2'b00;
  logic [2*W-1:0] a = '0;
  logic [2*W-1:0] b = '0;
  logic [1:0]     gnt;
  logic [1:0]     done;
  logic [2*W-1:0] result;
  logic           ovf;
  logic           busy;

  signed_alu_sched #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b),
    .gnt(gnt), .done(done), .result(result), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             edge_no;
    logic [1:0]     val;
    logic [2*W-1:0] res;
    logic           ovf;
  } exp_t;

  exp_t           gnt_exp_q[$];
  exp_t           done_exp_q[$];
  logic [1:0]     gnt_log[$];
  logic [2*W-1:0] res_log[$];

  int             edge_cnt = 0;
  int             free_edge = 0;
  logic           last_srv = 1'b1;
  logic [2*W-1:0] held_res = '0;
  logic           held_ovf = 1'b0;
  int             vectors = 0;
  int             miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sval(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - (1 << W) : int'(v);
  endfunction

  // Reference model: one operation at a time, winner by round robin, result from integers.
  int   m_av, m_bv, m_r;
  logic m_w;
  exp_t m_e;
  always @(posedge clk) begin
    edge_cnt++;
    if (rst_n && edge_cnt >= free_edge && req != 2'b00) begin
      m_w  = (req == 2'b11) ? ~last_srv : req[1];
      m_av = sval(m_w ? a[2*W-1:W] : a[W-1:0]);
      m_bv = sval(m_w ? b[2*W-1:W] : b[W-1:0]);
      m_r  = (m_w ? op[1] : op[0]) ? m_av * m_bv : m_av + m_bv;
      m_e.edge_no = edge_cnt;
      m_e.val     = m_w ? 2'b10 : 2'b01;
      m_e.res     = m_r[2*W-1:0];
      m_e.ovf     = (m_r > (1 << (W-1)) - 1) || (m_r < -(1 << (W-1)));
      gnt_exp_q.push_back(m_e);
      m_e.edge_no = edge_cnt + ((m_w ? op[1] : op[0]) ? 3 : 2);
      done_exp_q.push_back(m_e);
      free_edge = edge_cnt + ((m_w ? op[1] : op[0]) ? 4 : 3);
      last_srv  = m_w;
    end
  end

  logic [1:0] mon_eg;
  exp_t       mon_ed;
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      check("rst_gnt", gnt, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_ovf", ovf, 0);
      check("rst_busy", busy, 0);
    end else begin
      mon_eg = 2'b00;
      if (gnt_exp_q.size() > 0 && gnt_exp_q[0].edge_no == edge_cnt) begin
        mon_eg = gnt_exp_q[0].val;
        void'(gnt_exp_q.pop_front());
      end
      check("gnt", gnt, mon_eg);
      if (done_exp_q.size() > 0 && done_exp_q[0].edge_no == edge_cnt) begin
        mon_ed   = done_exp_q.pop_front();
        held_res = mon_ed.res;
        held_ovf = mon_ed.ovf;
        check("done", done, mon_ed.val);
      end else begin
        check("done_idle", done, 0);
      end
      check("result", result, held_res);
      check("ovf", ovf, held_ovf);
      check("busy", busy, (edge_cnt < free_edge - 1) ? 1 : 0);
      if (gnt != 2'b00) gnt_log.push_back(gnt);
      if (done != 2'b00) res_log.push_back(result);
    end
  end

  task automatic do_reset(input int cyc);
    rst_n = 1'b0;
    gnt_exp_q.delete();
    done_exp_q.delete();
    free_edge = 0;
    last_srv  = 1'b1;
    held_res  = '0;
    held_ovf  = 1'b0;
    repeat (cyc) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (edge_cnt + 1 < free_edge && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (edge_cnt + 1 < free_edge) begin
      miscompares++;
      $display("FAIL wait_idle: model still busy after %0d cycles", n);
    end
  endtask

  task automatic single(input int r, input logic o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [2*W-1:0] er,
                        input logic eo, input bit scramble, input string name);
    wait_idle();
    req = 2'b00;
    req[r] = 1'b1;
    op[r] = o;
    if (r == 0) begin
      a[W-1:0] = av;
      b[W-1:0] = bv;
    end else begin
      a[2*W-1:W] = av;
      b[2*W-1:W] = bv;
    end
    @(negedge clk);
    req = 2'b00;
    if (scramble) begin
      a  = 12'($urandom);
      b  = 12'($urandom);
      op = ~op;
    end
    repeat (5) @(negedge clk);
    #2;
    check({name, "_result"}, result, er);
    check({name, "_ovf"}, ovf, eo);
  endtask

  initial begin
    do_reset(3);
    @(negedge clk);

    single(0, 1'b0, 6'd1, 6'd2, 12'd3, 1'b0, 0, "add_1_2");
    single(1, 1'b1, 6'h3D, 6'd2, 12'hFFA, 1'b0, 0, "mul_m3_2");
    single(0, 1'b0, 6'd31, 6'd1, 12'h020, 1'b1, 0, "add_31_1");
    single(1, 1'b1, 6'h20, 6'h20, 12'h400, 1'b1, 0, "mul_m32_m32");
    single(0, 1'b0, 6'h20, 6'd0, 12'hFE0, 1'b0, 0, "add_m32_0");
    single(1, 1'b0, 6'd10, 6'h3B, 12'd5, 1'b0, 1, "sample_at_grant");

    // Both requesters from reset, held high: grants must alternate starting with 0.
    @(negedge clk);
    do_reset(2);
    gnt_log.delete();
    res_log.delete();
    op  = 2'b10;
    a   = {6'd3, 6'd11};
    b   = {6'd3, 6'h39};
    req = 2'b11;
    repeat (14) @(negedge clk);
    req = 2'b00;
    repeat (6) @(negedge clk);
    check("rr_grant_count", (gnt_log.size() >= 3) ? 1 : 0, 1);
    check("rr_done_count", (res_log.size() >= 2) ? 1 : 0, 1);
    if (gnt_log.size() >= 3 && res_log.size() >= 2) begin
      check("rr_gnt0", gnt_log[0], 2'b01);
      check("rr_gnt1", gnt_log[1], 2'b10);
      check("rr_gnt2", gnt_log[2], 2'b01);
      check("rr_res0", res_log[0], 12'd4);
      check("rr_res1", res_log[1], 12'd9);
    end

    // Reset during multiply EXEC aborts the operation without a done pulse.
    wait_idle();
    res_log.delete();
    req = 2'b01;
    op  = 2'b01;
    a   = {6'd0, 6'd5};
    b   = {6'd0, 6'd7};
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    do_reset(2);
    repeat (6) @(negedge clk);
    check("abort_no_done", res_log.size(), 0);
    single(0, 1'b0, 6'd5, 6'd6, 12'd11, 1'b0, 0, "after_abort");

    // Random traffic; the model decides what the DUT must accept.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) != 0) begin
        req = 2'($urandom_range(0, 3));
        op  = 2'($urandom_range(0, 3));
        a   = 12'($urandom);
        b   = 12'($urandom);
      end
    end
    req = 2'b00;
    repeat (8) @(negedge clk);
    check("final_gnt_queue_empty", gnt_exp_q.size(), 0);
    check("final_done_queue_empty", done_exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
